// File: rtl/conv3x3_window_mac.sv
// conv3x3_window_mac
// Streaming 3x3 convolution over a raster-order 8-bit pixel stream.
// Two IMG_W-deep row delays feed a 3x3 window. Each valid (non-padded)
// window position produces one signed MAC result. The MAC pipeline is
// two register stages deep and runs every cycle with a valid tag, so
// input bubbles never duplicate or drop results.
// OW must be at least 17 (the width of one product); 20 covers 9*255*(-128).
module conv3x3_window_mac #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int OW    = 20
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [7:0]    i_pix_in,
    input  logic          i_pix_valid,
    input  logic          i_w_load,
    input  logic [3:0]    i_w_addr,
    input  logic [7:0]    i_w_data,
    output logic [OW-1:0] o_conv_out,
    output logic          o_conv_valid,
    output logic          o_frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0]       r_col;
    logic [RW-1:0]       r_row;
    logic [7:0]          r_line1 [IMG_W];
    logic [7:0]          r_line2 [IMG_W];
    logic [7:0]          r_win   [3][3];
    logic signed [7:0]   r_k     [9];
    logic signed [16:0]  r_prod  [9];
    logic                r_v0;
    logic                r_last0;
    logic                r_v1;
    logic                r_last1;

    logic                w_win_ok;
    logic                w_at_last;
    logic signed [OW-1:0] w_sum;

    // Window is real (not padded, not straddling a row wrap) only from row 2, column 2 on.
    assign w_win_ok  = (r_row >= ROW_TWO) && (r_col >= COL_TWO);
    assign w_at_last = (r_row == ROW_LAST) && (r_col == COL_LAST);

    // Raster position of the next pixel to be accepted; reset restarts at P(0,0).
    always_ff @(posedge clock) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_pix_valid) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Row delays and window shift on accepted pixels only; contents are never
    // cleared because the validity tag masks stale data.
    always_ff @(posedge clock) begin
        if (!reset && i_pix_valid) begin
            r_line1[0] <= i_pix_in;
            r_line2[0] <= r_line1[IMG_W-1];
            for (int k = 1; k < IMG_W; k++) begin
                r_line1[k] <= r_line1[k-1];
                r_line2[k] <= r_line2[k-1];
            end
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= r_win[i][2];
            end
            r_win[0][2] <= r_line2[IMG_W-1];
            r_win[1][2] <= r_line1[IMG_W-1];
            r_win[2][2] <= i_pix_in;
        end
    end

    // Kernel weights; addresses 9..15 fall outside the loop and are ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < 9; k++) begin
                r_k[k] <= '0;
            end
        end else if (i_w_load) begin
            for (int k = 0; k < 9; k++) begin
                if (i_w_addr == 4'(k)) begin
                    r_k[k] <= $signed(i_w_data);
                end
            end
        end
    end

    // Valid/last tags travel alongside the data through both MAC stages.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_v0    <= 1'b0;
            r_last0 <= 1'b0;
            r_v1    <= 1'b0;
            r_last1 <= 1'b0;
        end else begin
            r_v0    <= i_pix_valid && w_win_ok;
            r_last0 <= i_pix_valid && w_win_ok && w_at_last;
            r_v1    <= r_v0;
            r_last1 <= r_last0;
        end
    end

    // Stage 1: nine products of a zero-extended pixel and a signed weight.
    // The exact product always fits in 17 signed bits, so truncation is lossless.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                r_prod[3*i+j] <= $signed({9'd0, r_win[i][j]}) *
                                 $signed({{9{r_k[3*i+j][7]}}, r_k[3*i+j]});
            end
        end
    end

    // Adder tree over sign-extended products, no saturation.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < 9; k++) begin
            w_sum = w_sum + $signed({{(OW-17){r_prod[k][16]}}, r_prod[k]});
        end
    end

    // Stage 2: register result; conv_out holds its last value between results.
    always_ff @(posedge clock) begin
        if (reset) begin
            o_conv_out   <= '0;
            o_conv_valid <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_conv_valid <= r_v1;
            o_frame_done <= r_last1;
            if (r_v1) begin
                o_conv_out <= w_sum;
            end
        end
    end

endmodule
